adder_share_arbiter: RTL and testbench

- Shares one pipelined ADDER_WIDTH-bit adder among NUM_REQ requesters.
- Round-robin arbitration with a valid/ready handshake per requester.
- Each result is tagged with the requester ID, and the output handshake applies back-pressure.
- Sits in front of the arithmetic benchmark datapath so several operand sources can use a single adder at up to one operation per cycle.

---
 rtl/adder_share_arbiter.sv | 94 +++++++++
 tb/tb_adder_share_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one two-stage pipelined adder among NUM_REQ requesters.
// Results carry the requester ID and the output side applies back-pressure.
module adder_share_arbiter #(
  parameter int ADDER_WIDTH = 13,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0] req_b,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [ID_WIDTH-1:0]            resp_id,
  output logic [ADDER_WIDTH:0]           resp_sum,
  output logic                           busy,
  output logic [CNT_WIDTH-1:0]           done_count
);

  // Handshake: a beat moves when valid && ready on the same rising edge. req_ready may
  // follow req_valid combinationally, so requesters must never gate req_valid on req_ready.
  logic                   adv;
  logic                   found;
  logic                   transfer;
  logic [ID_WIDTH-1:0]    grant;
  logic [ID_WIDTH-1:0]    rr_ptr;
  logic [ADDER_WIDTH-1:0] sel_a;
  logic [ADDER_WIDTH-1:0] sel_b;
  logic                   s1_valid;
  logic [ADDER_WIDTH-1:0] s1_a;
  logic [ADDER_WIDTH-1:0] s1_b;
  logic [ID_WIDTH-1:0]    s1_id;

  assign adv  = !resp_valid || resp_ready;
  assign busy = s1_valid || resp_valid;

  // Scan from rr_ptr upward with wraparound; the first valid requester wins.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    sel_a = '0;
    sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = ID_WIDTH'(idx);
        sel_a = req_a[idx*ADDER_WIDTH +: ADDER_WIDTH];
        sel_b = req_b[idx*ADDER_WIDTH +: ADDER_WIDTH];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!reset && adv && found) req_ready = NUM_REQ'(1) << grant;
  end

  assign transfer = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_id      <= '0;
      resp_valid <= 1'b0;
      resp_sum   <= '0;
      resp_id    <= '0;
      done_count <= '0;
    end else begin
      if (transfer)
        rr_ptr <= (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
      // Both stages move together, so a drained result is refilled in the same cycle.
      if (adv) begin
        s1_valid   <= transfer;
        s1_a       <= sel_a;
        s1_b       <= sel_b;
        s1_id      <= grant;
        resp_valid <= s1_valid;
        resp_sum   <= {1'b0, s1_a} + {1'b0, s1_b};
        resp_id    <= s1_id;
      end
      if (resp_valid && resp_ready) done_count <= done_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: expected results are queued at issue time and
// popped by an independent monitor on every response handshake.
module tb_adder_share_arbiter;

  localparam int W  = 13;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_a;
  logic [N*W-1:0]    req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IW-1:0]     resp_id;
  logic [W:0]        resp_sum;
  logic              busy;
  logic [CW-1:0]     done_count;

  logic [N-1:0]      req_ready4;
  logic              resp_valid4;
  logic [IW-1:0]     resp_id4;
  logic [W:0]        resp_sum4;
  logic              busy4;
  logic [3:0]        done_count4;

  int tests = 0;
  int fails = 0;
  logic [IW+W:0] exp_q[$];

  always #5 clk = ~clk;

  adder_share_arbiter #(.ADDER_WIDTH(W), .NUM_REQ(N), .ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_sum(resp_sum), .busy(busy), .done_count(done_count)
  );

  adder_share_arbiter #(.ADDER_WIDTH(W), .NUM_REQ(N), .ID_WIDTH(IW), .CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready4),
    .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid4), .resp_ready(resp_ready),
    .resp_id(resp_id4), .resp_sum(resp_sum4), .busy(busy4), .done_count(done_count4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input int sum);
    exp_q.push_back({id[IW-1:0], sum[W:0]});
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*W +: W] = a[W-1:0];
    req_b[i*W +: W] = b[W-1:0];
  endtask

  // Inputs change just after the rising edge; checks happen on the falling edge.
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #2;
    reset     = 1'b1;
    req_valid = '1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done_count", done_count, 0);
    check("rst_resp_sum", resp_sum, 0);
    reset     = 1'b0;
    req_valid = '0;
  endtask

  task automatic drain;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_idle", busy, 0);
  endtask

  // Monitor: every response handshake must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp_unexpected: got id=%0d sum=%0d expected none at %0t",
                 resp_id, resp_sum, $time);
      end else begin
        logic [IW+W:0] e;
        e = exp_q.pop_front();
        check("resp_id_sum", {resp_id, resp_sum}, e);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    // Single op with maximal operands: carry lands in the MSB.
    do_reset();
    cyc();
    req_valid = 4'b0001;
    set_op(0, 8191, 8191);
    push_exp(0, 16382);
    @(negedge clk);
    check("single_req_ready", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    @(negedge clk);
    check("single_busy_s1", busy, 1);
    check("single_no_early_resp", resp_valid, 0);
    cyc();
    @(negedge clk);
    check("single_latency2", resp_valid, 1);
    cyc();
    @(negedge clk);
    check("single_done_count", done_count, 1);
    check("single_idle", busy, 0);

    // Round-robin fairness with all four requesters valid.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (k == 0) begin
        for (int i = 0; i < N; i++) set_op(i, i, 10);
        req_valid = 4'b1111;
      end
      @(negedge clk);
      check("rr_grant", req_ready, 32'(1) << (k % N));
      push_exp(k % N, 10 + (k % N));
      if (k >= 2) check("rr_stream", resp_valid, 1);
    end
    cyc();
    req_valid = '0;
    drain();
    check("rr_done_count", done_count, 6);

    // Back-pressure: requester 2 streams while resp_ready is low in cycles 3..6.
    begin
      int n;
      logic [N-1:0] exp_rdy;
      n = 0;
      for (int c = 0; c < 9; c++) begin
        cyc();
        resp_ready = (c >= 3 && c <= 6) ? 1'b0 : 1'b1;
        exp_rdy    = (c >= 3 && c <= 6) ? 4'b0000 : 4'b0100;
        req_valid  = 4'b0100;
        set_op(2, 8000 + n, 100 * n + 5);
        @(negedge clk);
        check("bp_req_ready", req_ready, exp_rdy);
        if (c >= 3 && c <= 6) begin
          check("bp_hold_valid", resp_valid, 1);
          check("bp_hold_sum", resp_sum, 8106);
          check("bp_hold_id", resp_id, 2);
        end
        if (exp_rdy != 0) begin
          push_exp(2, 8005 + 101 * n);
          n++;
        end
      end
      cyc();
      req_valid = '0;
      drain();
      check("bp_done_count", done_count, 11);
    end

    // Pointer skip: rr_ptr=1 with requesters 3 and 0 valid.
    do_reset();
    cyc();
    req_valid = 4'b0001;
    set_op(0, 1, 2);
    push_exp(0, 3);
    @(negedge clk);
    check("skip_setup", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b1001;
    set_op(3, 4000, 4000);
    set_op(0, 7, 9);
    push_exp(3, 8000);
    @(negedge clk);
    check("skip_grant3", req_ready, 4'b1000);
    cyc();
    push_exp(0, 16);
    @(negedge clk);
    check("skip_grant0", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b0011;
    set_op(1, 8191, 1);
    push_exp(1, 8192);
    @(negedge clk);
    check("skip_ptr1", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    drain();

    // Reset mid-flight: two ops accepted, then asynchronous reset between edges.
    do_reset();
    cyc();
    req_valid = 4'b0001;
    set_op(0, 11, 22);
    cyc();
    req_valid = 4'b0010;
    set_op(1, 33, 44);
    cyc();
    req_valid = '0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_stale", resp_valid, 0);
    end
    check("midrst_done_count", done_count, 0);
    cyc();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_op(i, 50 + i, 50);
    push_exp(0, 100);
    @(negedge clk);
    check("midrst_ptr0", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    drain();

    // Counter wrap: 17 handshakes on the 4-bit-counter instance reads back as 1.
    do_reset();
    for (int k = 0; k < 17; k++) begin
      cyc();
      req_valid = 4'b0001;
      set_op(0, k * 300, 1);
      push_exp(0, k * 300 + 1);
      @(negedge clk);
      check("wrap_req_ready", req_ready, 4'b0001);
    end
    cyc();
    req_valid = '0;
    drain();
    check("wrap_done_count16", done_count, 17);
    check("wrap_done_count4", done_count4, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
